// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between VGA fetch (priority) and the 6502 bus, with
// a starvation counter that guarantees the CPU a slot and a fixed 2-cycle response pipeline.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] TAG_NONE   = 2'd0;
  localparam logic [1:0] TAG_VID    = 2'd1;
  localparam logic [1:0] TAG_CPU_RD = 2'd2;
  localparam logic [1:0] TAG_CPU_WR = 2'd3;

  logic              vid_pend;
  logic [ADDR_W-1:0] vid_addr_q;
  logic              cpu_busy;
  logic [CNT_W-1:0]  starve_cnt;
  logic [1:0]        tag0;
  logic [1:0]        tag1;

  logic              vid_pend_c;
  logic [ADDR_W-1:0] vid_addr_c;
  logic              elig_c;
  logic              starve_win_c;
  logic              grant_vid_c;
  logic              grant_cpu_c;

  // Slot arbitration: a same-cycle vid_req counts as pending; the CPU only
  // overrides video once it has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    vid_pend_c   = vid_pend | vid_req;
    vid_addr_c   = vid_req ? vid_addr : vid_addr_q;
    elig_c       = cpu_req & ~cpu_busy & ~cpu_ack;
    starve_win_c = elig_c & (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_vid_c  = vid_pend_c & ~starve_win_c;
    grant_cpu_c  = elig_c & ~grant_vid_c;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      vid_overrun <= 1'b0;
      cpu_busy    <= 1'b0;
      starve_cnt  <= '0;
      tag0        <= TAG_NONE;
      tag1        <= TAG_NONE;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      vid_valid   <= 1'b0;
      vid_data    <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      vid_pend   <= vid_pend_c & ~grant_vid_c;
      vid_addr_q <= vid_addr_c;
      if (vid_req && vid_pend) vid_overrun <= 1'b1;

      if (grant_cpu_c || !elig_c) starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);

      // Busy spans grant to ack; the ack cycle itself is masked by cpu_ack.
      if (grant_cpu_c) cpu_busy <= 1'b1;
      else if (tag1[1]) cpu_busy <= 1'b0;

      ram_en <= grant_vid_c | grant_cpu_c;
      ram_we <= grant_cpu_c & cpu_we;
      if (grant_vid_c) begin
        ram_addr <= vid_addr_c;
        tag0     <= TAG_VID;
      end else if (grant_cpu_c) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        tag0      <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else begin
        tag0 <= TAG_NONE;
      end
      tag1 <= tag0;

      // Response stage: ram_rdata belongs to the access issued two edges ago.
      vid_valid <= (tag1 == TAG_VID);
      cpu_ack   <= tag1[1];
      if (tag1 == TAG_VID) vid_data <= ram_rdata;
      if (tag1 == TAG_CPU_RD) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a RAM model, a CPU handshake driver and a
// transaction-level reference model built from grant/latency/starvation rules.
module tb_vram_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int LIMIT = 4;
  localparam int NCYC  = 3000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM: read data appears the cycle after ram_en.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    bit            is_vid;
    bit            we;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t rq[$];
  int    vectors = 0;
  int    errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state
  bit            m_vpend;
  logic [AW-1:0] m_vaddr;
  int            m_starve;
  bit            m_ovr;
  int            cpu_done;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_vdata, e_crdata;

  // CPU driver state
  bit cpu_active, ack_seen;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = DW'(i * 7 + 3);
      shadow[i] = DW'(i * 7 + 3);
    end
    RST = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_active = 0; ack_seen = 0;
    m_vpend = 0; m_vaddr = '0; m_starve = 0; m_ovr = 0; cpu_done = -100;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_vdata = '0; e_crdata = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      bit            vp, elig, win, gv, gc;
      logic [AW-1:0] va;
      resp_t         r;
      bit            ev, ea;

      @(negedge CLK);
      RST = (cyc < 3) || (cyc >= 1500 && cyc < 1503);

      if (cyc >= 600 && cyc < 1000)       vid_req = 1'b1;
      else if (cyc < 600)                 vid_req = ($urandom_range(0, 3) == 0);
      else                                vid_req = ($urandom_range(0, 1) == 0);
      vid_addr = AW'($urandom_range(0, 31));

      if (RST) begin
        cpu_req = 1'b0; cpu_active = 0; ack_seen = 0;
      end else if (ack_seen) begin
        ack_seen = 0; cpu_active = 0;
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
      end else if (!cpu_active) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_active = 1;
          cpu_req    = 1'b1;
          cpu_we     = ($urandom_range(0, 1) == 1);
          cpu_addr   = AW'($urandom_range(0, 31));
          cpu_wdata  = DW'($urandom);
        end else begin
          cpu_req = 1'b0;
        end
      end

      // Model: decide this cycle's slot from the arbitration rules.
      if (RST) begin
        rq.delete();
        m_vpend = 0; m_vaddr = '0; m_starve = 0; m_ovr = 0; cpu_done = -100;
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_vdata = '0; e_crdata = '0;
      end else begin
        vp   = m_vpend || vid_req;
        va   = vid_req ? vid_addr : m_vaddr;
        if (vid_req && m_vpend) m_ovr = 1;
        elig = cpu_req && (cyc > cpu_done);
        win  = elig && (m_starve == LIMIT);
        gv   = vp && !win;
        gc   = elig && !gv;
        e_en = gv || gc;
        e_we = gc && cpu_we;
        if (gv) begin
          e_addr = va;
          r = '{is_vid: 1, we: 0, data: shadow[va], due: cyc + 3};
          rq.push_back(r);
        end else if (gc) begin
          e_addr  = cpu_addr;
          e_wdata = cpu_wdata;
          r = '{is_vid: 0, we: cpu_we, data: shadow[cpu_addr], due: cyc + 3};
          if (cpu_we) shadow[cpu_addr] = cpu_wdata;
          rq.push_back(r);
          cpu_done = cyc + 3;
        end
        m_vpend = vp && !gv;
        m_vaddr = va;
        if (gc || !elig)        m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
      end

      @(posedge CLK);
      #1;
      chk("ram_en", 32'(ram_en), 32'(e_en), cyc);
      chk("ram_we", 32'(ram_we), 32'(e_we), cyc);
      if (e_en) chk("ram_addr", 32'(ram_addr), 32'(e_addr), cyc);
      if (e_en && e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata), cyc);

      ev = 0; ea = 0;
      if (rq.size() > 0 && rq[0].due == cyc + 1) begin
        r = rq.pop_front();
        if (r.is_vid) begin
          ev = 1; e_vdata = r.data;
        end else begin
          ea = 1;
          if (!r.we) e_crdata = r.data;
        end
      end
      chk("vid_valid", 32'(vid_valid), 32'(ev), cyc);
      chk("cpu_ack", 32'(cpu_ack), 32'(ea), cyc);
      chk("vid_data", 32'(vid_data), 32'(e_vdata), cyc);
      chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crdata), cyc);
      chk("vid_overrun", 32'(vid_overrun), 32'(m_ovr), cyc);
      if (cpu_ack) ack_seen = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
